// File: rtl/led_pwm_pio_if.sv
// Avalon-MM slave bus bundle for the LED PWM/blink PIO.
// The bus master drives address, strobes and write data. The slave returns registered read data.
interface led_pwm_pio_if;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, write, writedata, read,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/led_pwm_pio.sv
// LED output peripheral with atomic set/clear, a shared-duty PWM dimmer and a blink generator.
// Both effects run from one prescaler tick, and each LED can select either effect.
module led_pwm_pio #(
  parameter int NUM_LEDS   = 8,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  led_pwm_pio_if.slave        avs_s0,
  output logic [NUM_LEDS-1:0] leds_export
);

  typedef enum logic [2:0] {
    A_OUT          = 3'd0,
    A_PWM_EN       = 3'd1,
    A_BLINK_EN     = 3'd2,
    A_DUTY         = 3'd3,
    A_PRESCALE     = 3'd4,
    A_BLINK_PERIOD = 3'd5,
    A_SET          = 3'd6,
    A_CLR          = 3'd7
  } reg_addr_e;

  reg_addr_e             addr;
  logic [NUM_LEDS-1:0]   wdata_leds;
  logic [NUM_LEDS-1:0]   out_q, pwm_en_q, blink_en_q, led_next;
  logic [PWM_BITS-1:0]   duty_q, pwm_cnt;
  logic [PRESCALE_W-1:0] prescale_q, blink_period_q, pcnt, bcnt;
  logic                  blink_phase, tick, pwm_on;
  logic                  wr_prescale, wr_blink_period;
  logic [31:0]           rd_mux;

  assign addr            = reg_addr_e'(avs_s0.address);
  assign wdata_leds      = avs_s0.writedata[NUM_LEDS-1:0];
  assign wr_prescale     = avs_s0.write && (addr == A_PRESCALE);
  assign wr_blink_period = avs_s0.write && (addr == A_BLINK_PERIOD);

  assign tick     = (pcnt == prescale_q);
  assign pwm_on   = (pwm_cnt < duty_q);
  assign led_next = out_q
                  & (~pwm_en_q   | {NUM_LEDS{pwm_on}})
                  & (~blink_en_q | {NUM_LEDS{blink_phase}});

  // NOTE: rd_mux gets a full default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_mux = '0;
    case (addr)
      A_OUT:          rd_mux[NUM_LEDS-1:0]   = out_q;
      A_PWM_EN:       rd_mux[NUM_LEDS-1:0]   = pwm_en_q;
      A_BLINK_EN:     rd_mux[NUM_LEDS-1:0]   = blink_en_q;
      A_DUTY:         rd_mux[PWM_BITS-1:0]   = duty_q;
      A_PRESCALE:     rd_mux[PRESCALE_W-1:0] = prescale_q;
      A_BLINK_PERIOD: rd_mux[PRESCALE_W-1:0] = blink_period_q;
      default:        rd_mux = '0;
    endcase
  end

  // NOTE: reset_reset is sampled only at the clock edge. Every flop, including readdata, is cleared together.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      out_q                <= '0;
      pwm_en_q             <= '0;
      blink_en_q           <= '0;
      duty_q               <= '0;
      prescale_q           <= '0;
      blink_period_q       <= '0;
      pcnt                 <= '0;
      pwm_cnt              <= '0;
      bcnt                 <= '0;
      blink_phase          <= 1'b1;
      leds_export          <= '0;
      avs_s0.readdata      <= '0;
      avs_s0.readdatavalid <= 1'b0;
    end else begin
      // rd_mux is built from pre-write state, so a read in the same cycle as a write returns the old value.
      avs_s0.readdatavalid <= avs_s0.read;
      if (avs_s0.read) avs_s0.readdata <= rd_mux;

      if (avs_s0.write) begin
        case (addr)
          A_OUT:          out_q          <= wdata_leds;
          A_PWM_EN:       pwm_en_q       <= wdata_leds;
          A_BLINK_EN:     blink_en_q     <= wdata_leds;
          A_DUTY:         duty_q         <= avs_s0.writedata[PWM_BITS-1:0];
          A_PRESCALE:     prescale_q     <= avs_s0.writedata[PRESCALE_W-1:0];
          A_BLINK_PERIOD: blink_period_q <= avs_s0.writedata[PRESCALE_W-1:0];
          A_SET:          out_q          <= out_q | wdata_leds;
          A_CLR:          out_q          <= out_q & ~wdata_leds;
          default:        ;
        endcase
      end

      if (wr_prescale || tick) pcnt <= '0;
      else                     pcnt <= pcnt + PRESCALE_W'(1);

      if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);

      if (wr_blink_period) begin
        bcnt        <= '0;
        blink_phase <= 1'b1;
      end else if (tick) begin
        if (bcnt == blink_period_q) begin
          bcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          bcnt <= bcnt + PRESCALE_W'(1);
        end
      end

      leds_export <= led_next;
    end
  end

endmodule

// File: tb/tb_led_pwm_pio.sv
// Directed bench for led_pwm_pio. Expected read data goes into a scoreboard queue when each read is issued.
// A negedge monitor pops that queue when readdatavalid appears, and LED values are checked against hand-derived patterns.
`timescale 1ns/1ps
module tb_led_pwm_pio;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] leds;

  always #5 clk = ~clk;

  led_pwm_pio_if bus ();

  led_pwm_pio #(
    .NUM_LEDS   (8),
    .PWM_BITS   (8),
    .PRESCALE_W (16)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .avs_s0      (bus),
    .leds_export (leds)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic        rd_prev  = 1'b0;
  bit          mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // A read accepted at a clock edge without reset must produce exactly one valid, one cycle later.
  always @(posedge clk) rd_prev <= bus.read && !rst;

  always @(negedge clk) begin
    if (mon_en && (bus.readdatavalid || rd_prev)) begin
      check("readdatavalid", {31'b0, bus.readdatavalid}, {31'b0, rd_prev});
      if (bus.readdatavalid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL read_unexpected: got data 0x%0h, expected no read", bus.readdata);
        end else begin
          check("readdata", bus.readdata, exp_q.pop_front());
        end
      end
    end
  end

  // All tasks start and end at a falling edge, so each strobe spans exactly one rising edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    @(negedge clk);
    bus.write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    bus.address = a;
    bus.read    = 1'b1;
    @(negedge clk);
    bus.read    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain_reads();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    check("read_drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] e;
    int          highs;
    int          k;

    bus.address   = '0;
    bus.write     = 1'b0;
    bus.writedata = '0;
    bus.read      = 1'b0;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // After reset, every register reads back as 0 and the LEDs are dark.
    check("reset_leds", {24'h0, leds}, 32'h0);
    for (int a = 0; a < 8; a++) bus_read(3'(a), 32'h0);
    drain_reads();
    check("reset_leds_after_reads", {24'h0, leds}, 32'h0);

    // OUT, SET and CLR: 0xA5 | 0x0F = 0xAF, then 0xAF & ~0x81 = 0x2E. The pins lag the register write by one more edge.
    bus_write(3'd0, 32'h0000_00A5);
    bus_write(3'd6, 32'h0000_000F);
    bus_write(3'd7, 32'h0000_0081);
    check("leds_before_clr_visible", {24'h0, leds}, 32'h0000_00AF);
    @(negedge clk);
    check("leds_after_clr", {24'h0, leds}, 32'h0000_002E);
    bus_read(3'd0, 32'h0000_002E);
    bus_read(3'd6, 32'h0);
    bus_read(3'd7, 32'h0);

    // Write-data bits above each register's width are dropped.
    bus_write(3'd3, 32'h0000_01FF);
    bus_write(3'd1, 32'hFFFF_FF00);
    bus_write(3'd4, 32'hABCD_1234);
    bus_write(3'd5, 32'h0001_0005);
    bus_read(3'd3, 32'h0000_00FF);
    bus_read(3'd1, 32'h0000_0000);
    bus_read(3'd4, 32'h0000_1234);
    bus_read(3'd5, 32'h0000_0005);
    drain_reads();

    // PWM test. Reset restarts pwm_cnt, and PRESCALE=0 ticks every cycle, so pwm_cnt = k mod 256 in cycle k after reset.
    // The pin after edge m therefore shows (m-1) mod 256 < DUTY.
    do_reset();
    bus_write(3'd0, 32'hFF);
    bus_write(3'd1, 32'h01);
    bus_write(3'd3, 32'd64);
    bus_write(3'd4, 32'd0);
    highs = 0;
    for (int m = 5; m < 5 + 512; m++) begin
      @(negedge clk);
      e = {24'h0, 7'h7F, (((m - 1) % 256) < 64)};
      check($sformatf("pwm_duty64_m%0d", m), {24'h0, leds}, e);
      if (m < 5 + 256) highs += int'(leds[0]);
    end
    check("pwm_high_count_per_period", highs, 64);
    bus_write(3'd3, 32'd0);
    for (int m = 1; m <= 260; m++) begin
      @(negedge clk);
      check($sformatf("pwm_duty0_m%0d", m), {24'h0, leds}, 32'h0000_00FE);
    end

    // Blink test. After edge B, pcnt starts at 1, so ticks fall on cycles 2 + 4j.
    // The tenth tick is on cycle 38 and flips the phase at edge B+39, so the pin goes low after B+40 and toggles every 40 edges after that.
    do_reset();
    bus_write(3'd0, 32'h02);
    bus_write(3'd2, 32'h02);
    bus_write(3'd4, 32'd3);
    bus_write(3'd5, 32'd9);
    for (int n = 1; n <= 125; n++) begin
      @(negedge clk);
      e = (((n / 40) % 2) == 0) ? 32'h2 : 32'h0;
      check($sformatf("blink_n%0d", n), {24'h0, leds}, e);
    end

    // PWM and blink together. pwm_on in cycle k is (k mod 256) < 128.
    // The blink phase restarts at 1 after the BLINK_PERIOD write at edge R+5 and flips every 50 cycles.
    do_reset();
    bus_write(3'd0, 32'h01);
    bus_write(3'd1, 32'h01);
    bus_write(3'd2, 32'h01);
    bus_write(3'd3, 32'd128);
    bus_write(3'd5, 32'd49);
    for (int m = 6; m < 300; m++) begin
      @(negedge clk);
      k = m - 1;
      e = (((k % 256) < 128) && ((((k - 5) / 50) % 2) == 0)) ? 32'h1 : 32'h0;
      check($sformatf("pwm_and_blink_m%0d", m), {24'h0, leds}, e);
    end

    // Reset arrives mid-blink together with a read. The read must be discarded and the LEDs must go dark.
    rst         = 1'b1;
    bus.address = 3'd0;
    bus.read    = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    bus.read    = 1'b0;
    check("midreset_leds", {24'h0, leds}, 32'h0);

    // Phase=1 and bcnt=0 with BLINK_PERIOD=0 mean the phase flips on every edge, starting high in the cycle after reset.
    bus_write(3'd0, 32'h01);
    bus_write(3'd2, 32'h01);
    for (int m = 3; m <= 20; m++) begin
      @(negedge clk);
      e = (((m - 1) % 2) == 0) ? 32'h1 : 32'h0;
      check($sformatf("midreset_phase_m%0d", m), {24'h0, leds}, e);
    end
    bus_read(3'd0, 32'h01);
    bus_read(3'd1, 32'h00);
    bus_read(3'd2, 32'h01);
    bus_read(3'd3, 32'h00);
    bus_read(3'd4, 32'h00);
    bus_read(3'd5, 32'h00);
    drain_reads();

    // A read and a write to OUT in the same cycle return the old value. The next read returns the new one.
    bus_write(3'd0, 32'h11);
    exp_q.push_back(32'h11);
    bus.address   = 3'd0;
    bus.writedata = 32'h22;
    bus.read      = 1'b1;
    bus.write     = 1'b1;
    @(negedge clk);
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus_read(3'd0, 32'h22);
    drain_reads();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pwm_pio.md
# led_pwm_pio

Parametrised LED output peripheral: the successor to the fixed 8-bit LED PIO in the Qsys system, exposed as an Avalon-MM slave. It adds per-bit atomic set/clear, a shared-duty PWM dimmer and a blink generator, both selectable per LED, driven from a programmable prescaler. It sits on the Nios II data master next to the SDRAM controller and drives the board LEDs directly.

## Interface
- NUM_LEDS, 8, number of LED outputs (1..32)
- PWM_BITS, 8, PWM counter and duty width (2..16)
- PRESCALE_W, 16, prescaler and blink-period register width (1..32)
- clk_clk  input  1  system clock; one clock, all logic on its rising edge
- reset_reset  input  1  synchronous, active-high reset
- avs_s0_address  input  3  word address of register
- avs_s0_write  input  1  write strobe, single cycle
- avs_s0_writedata  input  32  write data
- avs_s0_read  input  1  read strobe, single cycle
- avs_s0_readdata  output  32  registered read data, unused upper bits 0
- avs_s0_readdatavalid  output  1  high exactly one cycle after an accepted read
- leds_export  output  NUM_LEDS  LED drive, registered

## Operation
- Register map (word address): 0 OUT, 1 PWM_EN, 2 BLINK_EN, 3 DUTY, 4 PRESCALE, 5 BLINK_PERIOD, 6 SET, 7 CLR.
- OUT/PWM_EN/BLINK_EN: NUM_LEDS bits, writedata[NUM_LEDS-1:0]; DUTY: PWM_BITS bits; PRESCALE/BLINK_PERIOD: PRESCALE_W bits.
- SET write: OUT <= OUT | wdata. CLR write: OUT <= OUT & ~wdata. Reads of addr 6/7 return 0.
- No wait states; every read/write accepted the cycle it is presented.
- Prescaler: pcnt counts 0..PRESCALE; tick=1 for the cycle pcnt==PRESCALE, pcnt then reloads 0. PRESCALE=0 -> tick every cycle.
- PWM: pwm_cnt (PWM_BITS) increments on tick, wraps 2^PWM_BITS-1 -> 0. pwm_on = (pwm_cnt < DUTY), unsigned. DUTY=0 -> never on; DUTY=max -> on (2^PWM_BITS-1) of 2^PWM_BITS steps.
- Blink: bcnt counts ticks 0..BLINK_PERIOD; on tick with bcnt==BLINK_PERIOD, bcnt <= 0 and blink_phase toggles. BLINK_PERIOD=0 -> toggle every tick.
- Per LED i: led_next[i] = OUT[i] & (PWM_EN[i] ? pwm_on : 1) & (BLINK_EN[i] ? blink_phase : 1).
- Write to PRESCALE clears pcnt. Write to BLINK_PERIOD clears bcnt and sets blink_phase=1. Writes to DUTY do not disturb pwm_cnt.
- Simultaneous read and write same cycle: write performed, readdata returns pre-write value.
- Writedata bits above a register's width are ignored.

## Timing
- Reset (reset_reset high at a clock edge): all registers, pcnt, pwm_cnt, bcnt = 0; blink_phase = 1; leds_export = 0; avs_s0_readdata = 0; avs_s0_readdatavalid = 0. Reset mid-operation discards any pending read (no readdatavalid the following cycle).
- Read latency: readdata/readdatavalid valid in cycle N+1 for read in cycle N; readdatavalid low otherwise; back-to-back reads give back-to-back valid.
- Write -> leds_export: register updates at edge ending cycle N; leds_export reflects it at edge ending cycle N+1 (2-edge latency, from write strobe to pin).
- tick, pwm_on, blink_phase combine combinationally into led_next; only leds_export is the output register.
- PWM period = (PRESCALE+1) * 2^PWM_BITS clocks; blink half-period = (PRESCALE+1)*(BLINK_PERIOD+1) clocks.

## Test plan
- Reset then read all 8 addresses -> readdata 0 each, readdatavalid one cycle after each read, leds_export 0.
- Write OUT=0xA5, SET 0x0F, CLR 0x81 -> read OUT = 0x2E; leds_export = 0x2E two edges after CLR write strobe.
- OUT=0xFF, PWM_EN=0x01, DUTY=64, PRESCALE=0 -> leds_export[0] high 64 of every 256 cycles, contiguous from pwm_cnt=0; bits 7..1 constant 1; DUTY=0 -> bit 0 constant 0.
- OUT=0x02, BLINK_EN=0x02, PRESCALE=3, BLINK_PERIOD=9 -> leds_export[1] toggles every 40 cycles, first low 40 cycles after BLINK_PERIOD write; bits 7..2 and bit 0 stay 0.
- PWM_EN=BLINK_EN=0x01 with OUT[0]=1 -> bit 0 equals pwm_on AND blink_phase; assert reset_reset mid-blink -> leds_export 0 and all counters 0 next cycle, blink_phase 1.
- Read and write OUT same cycle (old 0x11, new 0x22) -> readdata 0x11, subsequent read 0x22.
